// File: rtl/bist_controller.sv
// Scan-chain self-test sequencer: walks LOAD/CAPTURE/SHIFT/UNLOAD for NUM_PATTERNS patterns,
// compacts the serial response into an 8-bit SISR and flags pass against GOLDEN_SIG.
module bist_controller #(
    parameter int unsigned CHAIN_LEN    = 8,
    parameter int unsigned NUM_PATTERNS = 16,
    parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              scan_out,
    output logic                              scan_en,
    output logic                              lfsr_en,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [7:0]                        signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0] pattern_cnt
);

    localparam int unsigned CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam int unsigned BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCapture,
        StShift,
        StUnload,
        StDone
    } state_t;

    state_t           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;

    logic             last_bit;
    logic [7:0]       sig_shift;

    assign last_bit  = (bit_cnt_q == BIT_W'(CHAIN_LEN - 1));
    // SISR step: taps 7,5,4,3 folded with the incoming response bit.
    assign sig_shift = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ scan_out};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
                    sig_d     = 8'h00;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                end
            end
            StLoad: begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = StCapture;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            StCapture: begin
                cnt_d     = cnt_q + CNT_W'(1);
                bit_cnt_d = '0;
                state_d   = (cnt_q < CNT_W'(NUM_PATTERNS - 1)) ? StShift : StUnload;
            end
            StShift: begin
                sig_d = sig_shift;
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = StCapture;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            StUnload: begin
                sig_d = sig_shift;
                if (last_bit) begin
                    bit_cnt_d = '0;
                    // Judge the signature including the bit compacted on this edge.
                    pass_d    = (sig_shift == GOLDEN_SIG);
                    state_d   = StDone;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            sig_q     <= 8'h00;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        scan_en = (state_q == StLoad) || (state_q == StShift) || (state_q == StUnload);
        lfsr_en = (state_q == StLoad) || (state_q == StShift);
        busy    = (state_q != StIdle) && (state_q != StDone);
        done    = (state_q == StDone);
    end

    assign pass        = pass_q;
    assign signature   = sig_q;
    assign pattern_cnt = cnt_q;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: cycle-offset reference model for the default-sized instances plus
// directed literal checks on a single-pattern instance.
module tb_bist_controller;

    localparam int CL  = 8;
    localparam int NP  = 16;
    localparam int TOT = CL + NP * (CL + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, scan_out;

    logic       a_scan_en, a_lfsr_en, a_busy, a_done, a_pass;
    logic [7:0] a_sig;
    logic [4:0] a_cnt;
    logic       b_scan_en, b_lfsr_en, b_busy, b_done, b_pass;
    logic [7:0] b_sig;
    logic [0:0] b_cnt;
    logic       c_scan_en, c_lfsr_en, c_busy, c_done, c_pass;
    logic [7:0] c_sig;
    logic [4:0] c_cnt;

    bist_controller #(.CHAIN_LEN(8), .NUM_PATTERNS(16), .GOLDEN_SIG(8'h00)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(a_scan_en), .lfsr_en(a_lfsr_en), .busy(a_busy), .done(a_done),
        .pass(a_pass), .signature(a_sig), .pattern_cnt(a_cnt)
    );

    bist_controller #(.CHAIN_LEN(8), .NUM_PATTERNS(1), .GOLDEN_SIG(8'hF4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(b_scan_en), .lfsr_en(b_lfsr_en), .busy(b_busy), .done(b_done),
        .pass(b_pass), .signature(b_sig), .pattern_cnt(b_cnt)
    );

    bist_controller #(.CHAIN_LEN(8), .NUM_PATTERNS(16), .GOLDEN_SIG(8'h01)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(c_scan_en), .lfsr_en(c_lfsr_en), .busy(c_busy), .done(c_done),
        .pass(c_pass), .signature(c_sig), .pattern_cnt(c_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within a run is tracked as a cycle offset from the start edge.
    logic       m_run, m_done, m_pass;
    int         m_k, m_cnt;
    logic [7:0] m_sig;

    function automatic logic [7:0] compact(input logic [7:0] s, input logic b);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ b};
    endfunction

    function automatic bit is_cap(input int k);
        return (k >= CL) && (((k - CL) % (CL + 1)) == 0);
    endfunction

    function automatic logic exp_se(input logic run, input int k);
        return run && !is_cap(k);
    endfunction

    function automatic logic exp_le(input logic run, input int k);
        if (!run) return 1'b0;
        if (k < CL) return 1'b1;
        return !is_cap(k) && (((k - CL) / (CL + 1)) < NP - 1);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_pass <= 1'b0;
            m_k    <= 0;
            m_sig  <= 8'h00;
            m_cnt  <= 0;
        end else if (m_run) begin
            if (is_cap(m_k)) m_cnt <= m_cnt + 1;
            else if (m_k >= CL) m_sig <= compact(m_sig, scan_out);
            m_k <= m_k + 1;
            if (m_k + 1 == TOT) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
                m_pass <= (compact(m_sig, scan_out) == 8'h00);
            end
        end else if (start) begin
            m_run  <= 1'b1;
            m_k    <= 0;
            m_sig  <= 8'h00;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_pass <= 1'b0;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_scan_en", 32'(a_scan_en), 32'(exp_se(m_run, m_k)));
            check("a_lfsr_en", 32'(a_lfsr_en), 32'(exp_le(m_run, m_k)));
            check("a_busy", 32'(a_busy), 32'(m_run));
            check("a_done", 32'(a_done), 32'(m_done));
            check("a_sig", 32'(a_sig), 32'(m_sig));
            check("a_cnt", 32'(a_cnt), 32'(m_cnt));
            if (m_done) check("a_pass", 32'(a_pass), 32'(m_pass));
            check("c_scan_en", 32'(c_scan_en), 32'(exp_se(m_run, m_k)));
            check("c_lfsr_en", 32'(c_lfsr_en), 32'(exp_le(m_run, m_k)));
            check("c_busy", 32'(c_busy), 32'(m_run));
            check("c_done", 32'(c_done), 32'(m_done));
            check("c_sig", 32'(c_sig), 32'(m_sig));
            check("c_cnt", 32'(c_cnt), 32'(m_cnt));
            if (m_done) check("c_pass", 32'(c_pass), 32'(m_sig == 8'h01));
        end
    end

    int mode = 0;
    int cyc  = 0;

    // Period-153 stream so that back-to-back runs see identical response bits.
    function automatic logic periodic_bit(input int i);
        return logic'((((i * 7) ^ (i >> 3)) + (i >> 5)) & 1);
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        case (mode)
            0: scan_out = 1'b0;
            1: scan_out = 1'b1;
            2: scan_out = 1'($urandom_range(0, 1));
            default: scan_out = periodic_bit(cyc % 153);
        endcase
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (!a_done && i < 400) begin
            tick();
            i++;
        end
        check(name, 32'(a_done), 32'd1);
    endtask

    logic [7:0] sig1;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        scan_out = 1'b0;

        // Reset held with start high.
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_scan_en", 32'(a_scan_en), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_sig", 32'(a_sig), 32'd0);
        check("rst_b_lfsr", 32'(b_lfsr_en), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("idle_busy", 32'(a_busy), 32'd0);
        check("idle_pass", 32'(a_pass), 32'd0);
        check("idle_cnt", 32'(a_cnt), 32'd0);

        // Single-pattern run with scan_out tied high: expected signature F4 at 17 cycles.
        mode     = 1;
        scan_out = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n <= 17; n++) begin
            check($sformatf("b_scan_en_%0d", n), 32'(b_scan_en), 32'(n != 8 && n < 17));
            check($sformatf("b_lfsr_en_%0d", n), 32'(b_lfsr_en), 32'(n < 8));
            check($sformatf("b_busy_%0d", n), 32'(b_busy), 32'(n < 17));
            check($sformatf("b_done_%0d", n), 32'(b_done), 32'(n == 17));
            if (n < 17) tick();
        end
        check("b_sig", 32'(b_sig), 32'h000000F4);
        check("b_pass", 32'(b_pass), 32'd1);
        check("b_cnt", 32'(b_cnt), 32'd1);
        wait_done("ones_done_timeout");

        // Zero stream with a stray start pulse mid-run.
        mode     = 0;
        scan_out = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 152; n++) begin
            if (n == 50) start = 1'b1;
            if (n == 151) check("zero_done_early", 32'(a_done), 32'd0);
            tick();
            start = 1'b0;
        end
        check("zero_done_152", 32'(a_done), 32'd1);
        check("zero_sig", 32'(a_sig), 32'h0);
        check("zero_cnt", 32'(a_cnt), 32'd16);
        check("zero_pass", 32'(a_pass), 32'd1);
        check("zero_c_pass", 32'(c_pass), 32'd0);
        check("zero_model_sig", 32'(m_sig), 32'h0);
        check("zero_model_cnt", 32'(m_cnt), 32'd16);

        // Random response stream.
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("rand_done_timeout");
        check("rand_pass", 32'(a_pass), 32'(m_sig == 8'h00));

        // Back-to-back runs with start held high.
        mode  = 3;
        start = 1'b1;
        tick();
        wait_done("b2b_done1_timeout");
        sig1 = a_sig;
        tick();
        check("b2b_done_1cyc", 32'(a_done), 32'd0);
        check("b2b_busy", 32'(a_busy), 32'd1);
        check("b2b_sig_clr", 32'(a_sig), 32'd0);
        wait_done("b2b_done2_timeout");
        check("b2b_sig_same", 32'(a_sig), 32'(sig1));
        start = 1'b0;
        tick();

        // Reset during SHIFT aborts the run.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("mid_lfsr_en", 32'(a_lfsr_en), 32'd1);
        check("mid_scan_en", 32'(a_scan_en), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_scan_en", 32'(a_scan_en), 32'd0);
        check("abort_sig", 32'(a_sig), 32'd0);
        check("abort_cnt", 32'(a_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_abort_busy", 32'(a_busy), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
